// File: rtl/rr_bus_arbiter_pkg.sv
// Shared definitions for the round-robin bus arbiter: state encodings,
// requester count, default hold limit and the round-robin pick function.
package rr_bus_arbiter_pkg;

    localparam int ARB_NREQ             = 4;
    localparam int ARB_MAX_HOLD_DEFAULT = 8;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Returns {found, index} of the first set request in the order
    // last+1, last+2, last+3, last (mod 4). With excl_last set, the
    // 'last' slot is skipped so the current owner cannot win again.
    function automatic logic [2:0] rr_pick(input logic [3:0] req,
                                           input logic [1:0] last,
                                           input logic       excl_last);
        logic [2:0] r;
        logic [1:0] idx;
        r = 3'b000;
        // Walk from lowest to highest priority so the highest one wins.
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx] && !(excl_last && (k == 4))) begin
                r = {1'b1, idx};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bit32_mux4to1.sv
// Combinational 4:1 word multiplexer for the shared result bus.
module bit32_mux4to1 #(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    output logic [WIDTH-1:0] out
);

    // Select one requester word by index.
    always_comb begin
        out = in1;
        case (sel)
            2'd0: out = in1;
            2'd1: out = in2;
            2'd2: out = in3;
            2'd3: out = in4;
            default: out = in1;
        endcase
    end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter for one shared result bus among four requesters.
// Tenure is bounded by a hold counter when others are waiting; the
// owner's word is registered onto the output bus.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | no owner, gnt = 0, waiting for any request
// ST_GRANT | one requester owns the bus; last/sel hold its index
module rr_bus_arbiter
    import rr_bus_arbiter_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MAX_HOLD = ARB_MAX_HOLD_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ARB_NREQ-1:0] req,
    input  logic [WIDTH-1:0]    in1,
    input  logic [WIDTH-1:0]    in2,
    input  logic [WIDTH-1:0]    in3,
    input  logic [WIDTH-1:0]    in4,
    output logic [ARB_NREQ-1:0] gnt,
    output logic [1:0]          sel,
    output logic [WIDTH-1:0]    out,
    output logic                out_valid
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [0:0]          state, state_nx;
    logic [1:0]          last, last_nx;
    logic [7:0]          hold_cnt, hold_nx;
    logic [ARB_NREQ-1:0] gnt_nx;
    logic [1:0]          sel_nx;
    logic [WIDTH-1:0]    mux_out;
    logic                owner_req;
    logic                others_req;
    logic                load;
    logic [2:0]          pick_all;
    logic [2:0]          pick_ex;

    // The mux is steered by the registered select, so data lags gnt by one cycle.
    bit32_mux4to1 #(.WIDTH(WIDTH)) u_mux (
        .sel (sel),
        .in1 (in1),
        .in2 (in2),
        .in3 (in3),
        .in4 (in4),
        .out (mux_out)
    );

    // While granted, 'last' is the owner's index.
    assign owner_req  = req[last];
    assign others_req = |(req & ~(4'b0001 << last));
    assign pick_all   = rr_pick(req, last, 1'b0);
    assign pick_ex    = rr_pick(req, last, 1'b1);
    assign load       = (state == ST_GRANT) && owner_req;

    // Next-state arbitration: initial grant, stay, release on drop, forced release.
    always_comb begin
        state_nx = state;
        last_nx  = last;
        hold_nx  = hold_cnt;
        gnt_nx   = gnt;
        sel_nx   = sel;
        case (state)
            ST_IDLE: begin
                if (pick_all[2]) begin
                    state_nx = ST_GRANT;
                    last_nx  = pick_all[1:0];
                    sel_nx   = pick_all[1:0];
                    gnt_nx   = 4'b0001 << pick_all[1:0];
                    hold_nx  = 8'd0;
                end
            end
            ST_GRANT: begin
                if (!owner_req) begin
                    hold_nx = 8'd0;
                    if (pick_all[2]) begin
                        last_nx = pick_all[1:0];
                        sel_nx  = pick_all[1:0];
                        gnt_nx  = 4'b0001 << pick_all[1:0];
                    end else begin
                        state_nx = ST_IDLE;
                        gnt_nx   = 4'b0000;
                    end
                end else if ((hold_cnt == HOLD_LAST) && others_req) begin
                    hold_nx = 8'd0;
                    last_nx = pick_ex[1:0];
                    sel_nx  = pick_ex[1:0];
                    gnt_nx  = 4'b0001 << pick_ex[1:0];
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_nx = hold_cnt + 8'd1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                gnt_nx   = 4'b0000;
            end
        endcase
    end

    // Control registers; reset leaves requester 0 with first priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            last     <= 2'd3;
            hold_cnt <= 8'd0;
            gnt      <= 4'b0000;
            sel      <= 2'd0;
        end else begin
            state    <= state_nx;
            last     <= last_nx;
            hold_cnt <= hold_nx;
            gnt      <= gnt_nx;
            sel      <= sel_nx;
        end
    end

    // Output bus: capture the owner's word while it is still requesting.
    always_ff @(posedge clk) begin
        if (reset) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= load;
            if (load) begin
                out <= mux_out;
            end
        end
    end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Self-checking bench for rr_bus_arbiter: a table of per-edge vectors on a
// MAX_HOLD=4 instance, plus a short hand sequence covering data latency and
// a MAX_HOLD=1 instance.
module tb_rr_bus_arbiter;

    localparam logic [31:0] D0 = 32'hA5A5_0001;
    localparam logic [31:0] D1 = 32'hB6B6_0002;
    localparam logic [31:0] D2 = 32'hC7C7_0003;
    localparam logic [31:0] D3 = 32'hD8D8_0004;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [31:0] in1 = D0, in2 = D1, in3 = D2, in4 = D3;
    logic [3:0]  gnt, gnt1;
    logic [1:0]  sel, sel1;
    logic [31:0] out, out1;
    logic        out_valid, out_valid1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rr_bus_arbiter #(.WIDTH(32), .MAX_HOLD(4)) dut (
        .clk(clk), .reset(reset), .req(req),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .gnt(gnt), .sel(sel), .out(out), .out_valid(out_valid)
    );

    rr_bus_arbiter #(.WIDTH(32), .MAX_HOLD(1)) dut1 (
        .clk(clk), .reset(reset), .req(req),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .gnt(gnt1), .sel(sel1), .out(out1), .out_valid(out_valid1)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  gnt;
        logic [1:0]  sel;
        logic [31:0] out;
        logic        v;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic [3:0] q, input logic [3:0] g,
                       input logic [1:0] s, input logic [31:0] o, input logic v);
        vec_t e;
        e.rst = r; e.req = q; e.gnt = g; e.sel = s; e.out = o; e.v = v;
        vecs.push_back(e);
    endtask

    initial begin
        // reset
        add(1, 4'b0000, 4'b0000, 2'd0, 32'h0, 0);
        // single requester 0
        add(0, 4'b0001, 4'b0001, 2'd0, 32'h0, 0);
        add(0, 4'b0001, 4'b0001, 2'd0, D0, 1);
        add(0, 4'b0001, 4'b0001, 2'd0, D0, 1);
        add(0, 4'b0001, 4'b0001, 2'd0, D0, 1);
        add(0, 4'b0000, 4'b0000, 2'd0, D0, 0);
        add(0, 4'b0000, 4'b0000, 2'd0, D0, 0);
        // rotation from reset, each owner drops after two data cycles
        add(1, 4'b0000, 4'b0000, 2'd0, 32'h0, 0);
        add(0, 4'b1111, 4'b0001, 2'd0, 32'h0, 0);
        add(0, 4'b1111, 4'b0001, 2'd0, D0, 1);
        add(0, 4'b1111, 4'b0001, 2'd0, D0, 1);
        add(0, 4'b1110, 4'b0010, 2'd1, D0, 0);
        add(0, 4'b1110, 4'b0010, 2'd1, D1, 1);
        add(0, 4'b1110, 4'b0010, 2'd1, D1, 1);
        add(0, 4'b1100, 4'b0100, 2'd2, D1, 0);
        add(0, 4'b1100, 4'b0100, 2'd2, D2, 1);
        add(0, 4'b1100, 4'b0100, 2'd2, D2, 1);
        add(0, 4'b1000, 4'b1000, 2'd3, D2, 0);
        add(0, 4'b1000, 4'b1000, 2'd3, D3, 1);
        add(0, 4'b1000, 4'b1000, 2'd3, D3, 1);
        // reset mid-burst, then 1001 grants 0
        add(1, 4'b1000, 4'b0000, 2'd0, 32'h0, 0);
        add(0, 4'b1001, 4'b0001, 2'd0, 32'h0, 0);
        add(0, 4'b1001, 4'b0001, 2'd0, D0, 1);
        // hold limit of 4 with 0011
        add(1, 4'b0000, 4'b0000, 2'd0, 32'h0, 0);
        add(0, 4'b0011, 4'b0001, 2'd0, 32'h0, 0);
        add(0, 4'b0011, 4'b0001, 2'd0, D0, 1);
        add(0, 4'b0011, 4'b0001, 2'd0, D0, 1);
        add(0, 4'b0011, 4'b0001, 2'd0, D0, 1);
        add(0, 4'b0011, 4'b0010, 2'd1, D0, 1);
        add(0, 4'b0011, 4'b0010, 2'd1, D1, 1);
        add(0, 4'b0011, 4'b0010, 2'd1, D1, 1);
        add(0, 4'b0011, 4'b0010, 2'd1, D1, 1);
        add(0, 4'b0011, 4'b0001, 2'd0, D1, 1);
        add(0, 4'b0011, 4'b0001, 2'd0, D0, 1);
        // lone requester keeps the bus; counter saturates
        add(0, 4'b0001, 4'b0001, 2'd0, D0, 1);
        add(0, 4'b0001, 4'b0001, 2'd0, D0, 1);
        add(0, 4'b0001, 4'b0001, 2'd0, D0, 1);
        add(0, 4'b0001, 4'b0001, 2'd0, D0, 1);
        add(0, 4'b0001, 4'b0001, 2'd0, D0, 1);
        // saturated counter forces release as soon as a contender appears
        add(0, 4'b0011, 4'b0010, 2'd1, D0, 1);
        // fairness: after owner 2, 0101 goes to 0
        add(0, 4'b0100, 4'b0100, 2'd2, D0, 0);
        add(0, 4'b0100, 4'b0100, 2'd2, D2, 1);
        add(0, 4'b0000, 4'b0000, 2'd2, D2, 0);
        add(0, 4'b0101, 4'b0001, 2'd0, D2, 0);
        add(0, 4'b0101, 4'b0001, 2'd0, D0, 1);
        // owner drop with no contenders
        add(0, 4'b0010, 4'b0010, 2'd1, D0, 0);
        add(0, 4'b0010, 4'b0010, 2'd1, D1, 1);
        add(0, 4'b0000, 4'b0000, 2'd1, D1, 0);
        add(0, 4'b0000, 4'b0000, 2'd1, D1, 0);

        foreach (vecs[i]) begin
            reset = vecs[i].rst;
            req   = vecs[i].req;
            step();
            check("gnt", i, 32'(gnt), 32'(vecs[i].gnt));
            check("sel", i, 32'(sel), 32'(vecs[i].sel));
            check("out", i, out, vecs[i].out);
            check("out_valid", i, 32'(out_valid), 32'(vecs[i].v));
        end

        // Data latency with changing input words, and MAX_HOLD=1 alternation.
        reset = 1'b1; req = 4'b0000;
        step();
        reset = 1'b0; req = 4'b0011;
        step();
        check("seq_gnt", 1, 32'(gnt), 32'h1);
        check("seq_gnt_h1", 1, 32'(gnt1), 32'h1);
        in1 = 32'h1234_0001;
        step();
        check("seq_out", 2, out, 32'h1234_0001);
        check("seq_out_h1", 2, out1, 32'h1234_0001);
        check("seq_gnt_h1", 2, 32'(gnt1), 32'h2);
        check("seq_sel_h1", 2, 32'(sel1), 32'h1);
        check("seq_valid_h1", 2, 32'(out_valid1), 32'h1);
        in1 = 32'h1234_0002;
        step();
        check("seq_out", 3, out, 32'h1234_0002);
        check("seq_gnt_h1", 3, 32'(gnt1), 32'h1);
        check("seq_out_h1", 3, out1, D1);
        check("seq_valid_h1", 3, 32'(out_valid1), 32'h1);
        step();
        check("seq_gnt_h1", 4, 32'(gnt1), 32'h2);
        check("seq_out_h1", 4, out1, 32'h1234_0002);
        check("seq_gnt", 4, 32'(gnt), 32'h1);
        req = 4'b0000;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_bus_arbiter.md
# rr_bus_arbiter

Round-robin arbiter sharing one 32-bit result bus among four requesters. It owns the `sel` input of a 32-bit 4:1 multiplexer and sequences bus ownership with a request/grant handshake. It bounds each owner's tenure with a hold counter and registers the selected word onto the shared output. It sits between the four producer units and the single downstream consumer.

## Interface
Parameters:
- `WIDTH`, default 32: data width per requester and on the output bus.
- `MAX_HOLD`, default 8: maximum consecutive grant cycles while others wait. Legal range is 1..256.

Ports:
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `req`, input, 4: per-requester bus request; `req[i]` is held while requester i has data.
- `in1`..`in4`, input, WIDTH each: requester data words 0..3.
- `gnt`, output, 4: one-hot grant, registered.
- `sel`, output, 2: mux select, registered; equals the index of `gnt`.
- `out`, output, WIDTH: registered bus data.
- `out_valid`, output, 1: `out` holds a word transferred from the owner.

## Operation
- **States.** IDLE (`gnt`=0) and GRANT (exactly one `gnt` bit set).
- **Pointer.** `last[1:0]` holds the index of the most recent owner. Search order is `last+1`, `last+2`, `last+3`, `last`, all modulo 4.
- **IDLE → GRANT.** Taken when any `req` bit is set. Grant goes to the first set `req` in search order. `last` and `sel` are set to that index; `hold_cnt` is cleared.
- **GRANT, stay.** The owner's `req` stays high and either `hold_cnt` < MAX_HOLD-1 or no other `req` is set. `hold_cnt` increments and saturates at MAX_HOLD-1.
- **GRANT, release on drop.** The owner's `req` is low. The next owner is picked in search order from the current `req` with no bubble cycle; if no `req` is set, go to IDLE.
- **GRANT, forced release.** `hold_cnt` == MAX_HOLD-1, the owner's `req` is high, and another `req` is set. Grant passes to the next set `req` in search order, excluding the current owner. `hold_cnt` is cleared.
- **Data.** In GRANT with the owner's `req` high, on each edge `out` ← mux(`sel`, `in1`..`in4`) and `out_valid` ← 1. Otherwise `out_valid` ← 0 and `out` holds its value.
- **Request timing.** Requests that appear or vanish mid-grant affect only the next arbitration decision. A requester must not change its data word in the same cycle it drops `req`.
- **Width rule.** `hold_cnt` is 8 bits. For MAX_HOLD = 1, every cycle with a competing request is a forced release.

## Timing
- **Reset values.** `gnt`=0, `sel`=0, `out`=0, `out_valid`=0, state IDLE, `hold_cnt`=0, `last`=3, so requester 0 has first priority after reset.
- **Request to grant.** 1 cycle: `req` sampled at edge N gives `gnt` valid after edge N.
- **Grant to data.** `out_valid` first rises 1 cycle after `gnt`; data latency from `in` to `out` is 1 cycle.
- **Handoff.** The new owner's `gnt` replaces the old one at the same edge, never two bits at once. `out_valid` stays high across the handoff if the new owner is requesting.
- **Reset mid-grant.** All outputs return to their reset values on the reset edge, and any in-flight word is dropped.
- **Simultaneous requests.** A simultaneous rise of all `req` bits from reset grants 0, 1, 2, 3 in order.

## Structure
- Shared include `arb_defs.vh` holds:
  - state encodings (IDLE=1'b0, GRANT=1'b1);
  - `ARB_NREQ`=4;
  - default `MAX_HOLD`.
- Sub-module: the existing `bit32_mux4to1`, instantiated once for the data path, driven by the registered `sel`. The arbiter FSM, pointer and counter live in `rr_bus_arbiter`.

## Test plan
- **Single requester.** Reset, then `req`=4'b0001 for 3 cycles with `in1`=32'hA5A5_0001. Expect `gnt`=0001 after 1 cycle, then `out`=A5A5_0001 with `out_valid`=1 for 3 cycles, then IDLE with `out_valid`=0.
- **Rotation.** `req`=4'b1111, each requester drops after 2 data cycles. Expect grants 0→1→2→3 with no idle gap, each `out` matching `in` of the owner.
- **Hold limit.** MAX_HOLD=4, `req`=4'b0011 held high. Expect `gnt` to alternate 0001/0010 every 4 cycles. With `req`=4'b0001 alone, the grant persists indefinitely.
- **Fairness after an owner.** After granting 2, raise `req`=4'b0101. Expect the next grant to 0 (search order 3,0,1,2), not 2.
- **Reset mid-burst.** Assert `reset` during a GRANT to 3 with `out_valid`=1. Next cycle expect `gnt`=0, `sel`=0, `out`=0, `out_valid`=0. With `req`=4'b1001 afterwards, expect a grant to 0.
- **Owner drop with no contenders.** `req`=0010, then `req`=0000. Expect `gnt`=0 one edge later and `out` holding its last word.
